// File: rtl/uart_loader_ctrl.sv
// Boot loader: takes a length-prefixed byte stream from the UART, packs it into 32-bit words for core memory, then releases the core.
// Optional LOADER_ACK_EN adds a one-byte acknowledge handshake (tx_*) before the release.
module uart_loader_ctrl #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_BYTES = 131072
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    input  logic              mem_wready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              cpu_start,
    output logic              err_overrun,
`ifdef LOADER_ACK_EN
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
`endif
    output logic              err_oversize
);

    localparam int unsigned LEN_W = 32;
    localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_RST = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_DRAIN,
`ifdef LOADER_ACK_EN
        S_ACK,
`endif
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [31:0]       asm_q, asm_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_stall_q, cpu_stall_d;
    logic              cpu_start_q, cpu_start_d;
    logic              err_overrun_q, err_overrun_d;
    logic              err_oversize_q, err_oversize_d;
`ifdef LOADER_ACK_EN
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
`endif

    logic [1:0]        lane_c;
    logic [31:0]       word_c;
    logic [LEN_W-1:0]  hdr_len_c;
    logic              last_c;

    // Next-state and datapath
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        len_d          = len_q;
        asm_d          = asm_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        err_overrun_d  = err_overrun_q;
        err_oversize_d = err_oversize_q;
`ifdef LOADER_ACK_EN
        tx_valid_d     = tx_valid_q;
        tx_data_d      = tx_data_q;
`endif

        lane_c    = cnt_q[1:0];
        hdr_len_c = {rx_data, len_q[23:0]};
        last_c    = ((cnt_q + LEN_W'(1)) == len_q);
        // Lane 0 starts a fresh word so a short final word is zero-padded
        word_c    = (lane_c == 2'd0) ? 32'h0 : asm_q;
        word_c[{lane_c, 3'b000} +: 8] = rx_data;

        // A completed handshake retires the held word and advances the address
        if (mem_we_q && mem_wready) begin
            mem_we_d   = 1'b0;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_HDR: begin
                if (rx_valid) begin
                    len_d[{lane_c, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + LEN_W'(1);
                    if (lane_c == 2'd3) begin
                        cnt_d          = '0;
                        err_oversize_d = err_oversize_q | (hdr_len_c > MAX_LEN);
                        state_d        = (hdr_len_c == '0) ? S_DONE : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (rx_valid) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    asm_d = word_c;
                    if ((lane_c == 2'd3 || last_c) && (cnt_q < MAX_LEN)) begin
                        if (mem_we_q && !mem_wready) begin
                            err_overrun_d = 1'b1;
                        end
                        mem_we_d    = 1'b1;
                        mem_wdata_d = word_c;
                    end
                    if (last_c) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!mem_we_q || mem_wready) begin
`ifdef LOADER_ACK_EN
                    state_d    = S_ACK;
                    tx_valid_d = 1'b1;
                    tx_data_d  = (err_overrun_q || err_oversize_q) ? 8'hEE : 8'hAA;
`else
                    state_d    = S_DONE;
`endif
                end
            end
`ifdef LOADER_ACK_EN
            S_ACK: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase

        cpu_stall_d = (state_d != S_DONE);
        cpu_start_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_HDR;
            cnt_q          <= '0;
            len_q          <= '0;
            asm_q          <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= ADDR_RST;
            mem_wdata_q    <= '0;
            cpu_stall_q    <= 1'b1;
            cpu_start_q    <= 1'b0;
            err_overrun_q  <= 1'b0;
            err_oversize_q <= 1'b0;
`ifdef LOADER_ACK_EN
            tx_valid_q     <= 1'b0;
            tx_data_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            asm_q          <= asm_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cpu_stall_q    <= cpu_stall_d;
            cpu_start_q    <= cpu_start_d;
            err_overrun_q  <= err_overrun_d;
            err_oversize_q <= err_oversize_d;
`ifdef LOADER_ACK_EN
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
`endif
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_stall    = cpu_stall_q;
    assign cpu_start    = cpu_start_q;
    assign err_overrun  = err_overrun_q;
    assign err_oversize = err_oversize_q;
`ifdef LOADER_ACK_EN
    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
`endif

endmodule

// File: doc/uart_loader_ctrl.md
# uart_loader_ctrl

Sequences the boot-time program/data load of the VLIW core from the UART receiver. Consumes the byte stream: a 4-byte little-endian length header, then payload bytes. Packs payload bytes little-endian into 32-bit words and writes them through a valid/ready port to sequential word addresses of core memory. Holds the core stalled until the load completes, then releases it with a start pulse. Sits between `uart_rx` and the memory write port, ahead of the core's `stall` input.

## Interface

- `ADDR_W`, 15: word-address width of the memory write port.
- `BASE_ADDR`, 0: word address of the first payload word.
- `MAX_BYTES`, 131072: payload capacity in bytes; payload beyond it is discarded.

Ports:

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, new received byte. No backpressure.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `mem_we` out 1: write request (valid).
- `mem_wready` in 1: memory accepts the write on cycles where `mem_we && mem_wready`.
- `mem_addr` out ADDR_W: word address.
- `mem_wdata` out 32: packed word; byte 0 received goes to bits [7:0].
- `cpu_stall` out 1: high while the load is pending.
- `cpu_start` out 1: one-cycle pulse when the core is released.
- `err_overrun` out 1: sticky; a word completed while the previous write was still pending.
- `err_oversize` out 1: sticky; header length exceeded `MAX_BYTES`.
- `tx_valid`, `tx_data[7:0]`, `tx_ready`: acknowledge port. Present only with `LOADER_ACK_EN`.

## Operation

States: HDR, LOAD, DRAIN, ACK (macro only), DONE.

- **HDR**
  - Count accepted bytes 0..3 into the 32-bit length register, little-endian.
  - After byte 3:
    - length == 0 → DONE.
    - otherwise → LOAD, with the byte counter cleared.
- **LOAD**
  - Each byte is shifted into the word assembler at lane (count mod 4).
  - When lane 3 is filled, or the last payload byte arrives:
    - latch the word, with unfilled upper lanes zero-padded, into the write holding register;
    - assert `mem_we`.
  - After the last payload byte → DRAIN.
- **Capacity limit**
  - Bytes with index ≥ `MAX_BYTES` are counted but not written.
  - `err_oversize` is set when the header is decoded.
- **Overrun**
  - Applies when a new word completes while `mem_we` is still high.
  - The new word overwrites the holding register, the old word is lost, and `err_overrun` is set.
  - The address still advances once per accepted write.
- **DRAIN**
  - Wait for the pending write handshake, if any.
  - Then → ACK (macro) or DONE.
- **ACK** (macro only): see Configuration.
- **DONE**
  - `cpu_stall` is 0 and `rx_valid` is ignored.
  - Terminal state; a new load requires `rst`.
- **Address**
  - `mem_addr` = `BASE_ADDR` + number of completed write handshakes.
  - Wraps modulo 2^ADDR_W.

## Timing

- **Reset values:**
  - state = HDR; `cpu_stall` = 1.
  - `cpu_start`, `mem_we`, `err_*`, `tx_valid` = 0.
  - `mem_addr` = `BASE_ADDR`; `mem_wdata` = 0.
- **Write latency:** `mem_we` rises on the cycle after the edge that captured the word-completing byte.
- **Write handshake:**
  - `mem_we`, `mem_addr` and `mem_wdata` are stable until the handshake edge.
  - `mem_we` drops the following cycle unless a new word completes on the handshake edge itself. In that case it stays high with the next address and data, and no overrun is flagged.
- **Release:**
  - `cpu_start` pulses on the first cycle in DONE.
  - `cpu_stall` falls on the same cycle and stays low.
  - Without the macro: one cycle after the final write handshake. Zero-length payload: one cycle after the 4th header byte.
- **Reset mid-load:** all state is aborted immediately and `cpu_stall` reasserts. A pending write is dropped without a handshake.

## Configuration

- **`LOADER_ACK_EN` defined:**
  - DRAIN → ACK.
  - ACK drives `tx_valid` = 1 with `tx_data` = 8'hAA until `tx_ready`.
  - On the handshake edge → DONE; `cpu_start` pulses on the next cycle.
  - If any `err_*` is set, `tx_data` = 8'hEE instead.
- **Not defined:**
  - No tx ports and no ACK state.
  - DRAIN → DONE directly.

## Test plan

- Header 32,0,0,0 then bytes 0x00..0x1F, `mem_wready` tied 1 → eight writes, addr 0..7. Word 0 = 32'h03020100, word 7 = 32'h1F1E1D1C. `cpu_start` pulses once, one cycle after the last write (macro off).
- Header 6,0,0,0, bytes 11 22 33 44 55 66 → two writes: 32'h44332211 then 32'h00006655. No error flags.
- Header 0,0,0,0 → no `mem_we`. `cpu_stall` falls and `cpu_start` pulses on the cycle after the 4th byte.
- `mem_wready` held 0 for 60 cycles on word 0, bytes arriving every 10 cycles → `err_overrun` = 1 and word 1 overwrites the holding register. After releasing `mem_wready`, one write is accepted at addr 0 with word-1 data.
- Assert `rst` after 17 payload bytes, then reload an 8-byte image → `cpu_stall` reasserts immediately, and writes restart at `BASE_ADDR` with the new data.
- With `LOADER_ACK_EN`: 4-byte load, `tx_ready` delayed 5 cycles → `tx_valid` held with 8'hAA. `cpu_start` pulses one cycle after the tx handshake and `cpu_stall` stays 1 until then.
